// File: rtl/mix_columns_engine.sv
// Pipelined AES MixColumns / InvMixColumns / bypass stage with valid-ready flow control.
// The inverse runs as a {05,00,04,00} pre-multiply in stage 1, followed by the forward matrix in the last stage.
module mix_columns_engine #(
  parameter int NCOL   = 4,
  parameter int PIPE   = 2,
  parameter int INV_EN = 1,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic               in_bypass,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [0:32*NCOL-1] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TAG_W-1:0]   out_tag,
  output logic [0:32*NCOL-1] data_out,
  output logic               idle
);

  localparam int W = 32 * NCOL;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] xtime_col(input logic [31:0] c);
    return {xtime(c[31:24]), xtime(c[23:16]), xtime(c[15:8]), xtime(c[7:0])};
  endfunction

  function automatic logic [31:0] premul_col(input logic [31:0] c);
    logic [7:0] a;
    logic [7:0] b;
    a = xtime(xtime(c[31:24] ^ c[15:8]));
    b = xtime(xtime(c[23:16] ^ c[7:0]));
    return c ^ {a, b, a, b};
  endfunction

  // x holds the bytewise xtime of c, so the 2s and 3s coefficients are x and x^s.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic [31:0] x);
    logic [7:0] s0, s1, s2, s3, x0, x1, x2, x3;
    {s0, s1, s2, s3} = c;
    {x0, x1, x2, x3} = x;
    return {x0 ^ x1 ^ s1 ^ s2 ^ s3,
            x1 ^ x2 ^ s0 ^ s2 ^ s3,
            x2 ^ x3 ^ s0 ^ s1 ^ s3,
            x3 ^ x0 ^ s0 ^ s1 ^ s2};
  endfunction

  function automatic logic [0:W-1] premul_beat(input logic [0:W-1] d);
    logic [0:W-1] r;
    r = d;
    for (int c = 0; c < NCOL; c++) r[32*c +: 32] = premul_col(d[32*c +: 32]);
    return r;
  endfunction

  function automatic logic [0:W-1] xtime_beat(input logic [0:W-1] d);
    logic [0:W-1] r;
    r = d;
    for (int c = 0; c < NCOL; c++) r[32*c +: 32] = xtime_col(d[32*c +: 32]);
    return r;
  endfunction

  function automatic logic [0:W-1] mix_beat(input logic [0:W-1] d, input logic [0:W-1] x);
    logic [0:W-1] r;
    r = d;
    for (int c = 0; c < NCOL; c++) r[32*c +: 32] = mix_col(d[32*c +: 32], x[32*c +: 32]);
    return r;
  endfunction

  logic [PIPE:1]    valid_r;
  logic [TAG_W-1:0] tag_r [1:PIPE];
  logic [PIPE:1]    take_s;
  logic [PIPE:1]    ld_s;
  logic             acc_s;
  logic             started_r;
  logic             in_acc_s;
  logic             inv_s;
  logic [0:W-1]     pre_s;

  assign inv_s    = (INV_EN != 0) ? (in_inv & ~in_bypass) : 1'b0;
  assign pre_s    = inv_s ? premul_beat(data_in) : data_in;
  assign in_ready = started_r & take_s[1];
  assign in_acc_s = in_valid & in_ready;

  // Stage k may load when it, or any stage downstream of it, is empty, or the output drains.
  always_comb begin
    take_s = '0;
    acc_s  = out_ready;
    for (int k = PIPE; k >= 1; k--) begin
      acc_s     = acc_s | ~valid_r[k];
      take_s[k] = acc_s;
    end
  end

  // A stage captures a real beat only when it may load and its upstream holds one.
  always_comb begin
    ld_s    = '0;
    ld_s[1] = take_s[1] & in_acc_s;
    for (int k = 2; k <= PIPE; k++) ld_s[k] = take_s[k] & valid_r[k-1];
  end

  // Stage occupancy and sideband tags; started_r keeps in_ready low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_r <= 1'b0;
      valid_r   <= '0;
      for (int k = 1; k <= PIPE; k++) tag_r[k] <= '0;
    end else begin
      started_r <= 1'b1;
      if (take_s[1]) valid_r[1] <= in_acc_s;
      if (ld_s[1])   tag_r[1]   <= in_tag;
      for (int k = 2; k <= PIPE; k++) begin
        if (take_s[k]) valid_r[k] <= valid_r[k-1];
        if (ld_s[k])   tag_r[k]   <= tag_r[k-1];
      end
    end
  end

  assign out_valid = valid_r[PIPE];
  assign out_tag   = tag_r[PIPE];
  assign idle      = ~|valid_r;

  if (PIPE == 1) begin : g_p1
    logic [0:W-1] d1_r;
    // Single stage: pre-multiply and forward matrix both resolve before the one register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        d1_r <= '0;
      end else if (ld_s[1]) begin
        d1_r <= in_bypass ? data_in : mix_beat(pre_s, xtime_beat(pre_s));
      end
    end
    assign data_out = d1_r;
  end else if (PIPE == 2) begin : g_p2
    logic [0:W-1] d1_r, d2_r;
    logic         byp1_r;
    // Stage 1 holds the pre-multiplied beat, stage 2 the mixed result.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        d1_r   <= '0;
        byp1_r <= 1'b0;
        d2_r   <= '0;
      end else begin
        if (ld_s[1]) begin
          d1_r   <= pre_s;
          byp1_r <= in_bypass;
        end
        if (ld_s[2]) d2_r <= byp1_r ? d1_r : mix_beat(d1_r, xtime_beat(d1_r));
      end
    end
    assign data_out = d2_r;
  end else begin : g_p3
    logic [0:W-1] d1_r, d2_r, x2_r, d3_r;
    logic         byp1_r, byp2_r;
    // Stage 2 registers the xtime terms so stage 3 only has the XOR network.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        d1_r   <= '0;
        byp1_r <= 1'b0;
        d2_r   <= '0;
        x2_r   <= '0;
        byp2_r <= 1'b0;
        d3_r   <= '0;
      end else begin
        if (ld_s[1]) begin
          d1_r   <= pre_s;
          byp1_r <= in_bypass;
        end
        if (ld_s[2]) begin
          d2_r   <= d1_r;
          x2_r   <= xtime_beat(d1_r);
          byp2_r <= byp1_r;
        end
        if (ld_s[3]) d3_r <= byp2_r ? d2_r : mix_beat(d2_r, x2_r);
      end
    end
    assign data_out = d3_r;
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine: NCOL=4/PIPE=2 main instance, a PIPE=3 twin and an NCOL=1 instance.
module tb_mix_columns_engine;

  localparam logic [127:0] VA  = 128'h632FAFA2EB93C7209F92ABCBA0C0302B;
  localparam logic [127:0] FA  = 128'hBA75F47A84A48D32E88D060E1B407D5D;
  localparam logic [127:0] VB  = 128'h1A5BE9A9AB30D2AA0141D3E827B4BABB;
  localparam logic [127:0] FB  = 128'h992568D5650CC14BFA05DE5A883A2A0A;
  localparam logic [127:0] VX2 = 128'h473794ED40D4E4A5A3703AA64C9F42BC;
  localparam logic [127:0] IX2 = 128'h876E46A6F24CE78C4D904AD897ECC395;
  localparam logic [127:0] VC  = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_inv = 1'b0, in_bypass = 1'b0, out_ready = 1'b1;
  logic [3:0]   in_tag = 4'd0;
  logic [0:127] data_in = '0;
  logic         in_ready, out_valid, idle;
  logic [3:0]   out_tag;
  logic [0:127] data_out;

  logic         r3_ready, v3_out, idle3;
  logic [3:0]   tag3_out;
  logic [0:127] data3_out;

  logic         v1_in = 1'b0, inv1_in = 1'b0, byp1_in = 1'b0;
  logic [3:0]   tag1_in = 4'd0;
  logic [0:31]  data1_in = '0;
  logic         r1_ready, v1_out, idle1;
  logic [3:0]   tag1_out;
  logic [0:31]  data1_out;

  int checks = 0;
  int failures = 0;

  mix_columns_engine #(.NCOL(4), .PIPE(2), .INV_EN(1), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_bypass(in_bypass), .in_tag(in_tag), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_tag(out_tag), .data_out(data_out), .idle(idle));

  mix_columns_engine #(.NCOL(4), .PIPE(3), .INV_EN(1), .TAG_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r3_ready), .in_inv(in_inv),
    .in_bypass(in_bypass), .in_tag(in_tag), .data_in(data_in), .out_valid(v3_out),
    .out_ready(1'b1), .out_tag(tag3_out), .data_out(data3_out), .idle(idle3));

  mix_columns_engine #(.NCOL(1), .PIPE(2), .INV_EN(1), .TAG_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1_in), .in_ready(r1_ready), .in_inv(inv1_in),
    .in_bypass(byp1_in), .in_tag(tag1_in), .data_in(data1_in), .out_valid(v1_out),
    .out_ready(1'b1), .out_tag(tag1_out), .data_out(data1_out), .idle(idle1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  logic [127:0] s_in  [6] = '{VA, VB, FA, VA, VX2, VB};
  logic [127:0] s_exp [6] = '{FA, FB, VA, FA, IX2, FB};
  logic         s_inv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0]   s_tag [6] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd4};

  logic [127:0] p_in  [4] = '{VA, VB, FA, VC};
  logic [127:0] p_exp [4] = '{FA, FB, VA, VC};
  logic         p_inv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic         p_byp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic [31:0]  n_in  [5] = '{32'hDB135345, 32'hF20A225C, 32'h01010101, 32'h8E4DA1BC, 32'hC6C6C6C6};
  logic [31:0]  n_exp [5] = '{32'h8E4DA1BC, 32'h9FDC589D, 32'h01010101, 32'hDB135345, 32'hC6C6C6C6};
  logic         n_inv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic         n_byp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  int sent;
  int got;

  initial begin
    // reset with in_valid held high
    #2 rst = 1'b0;
    in_valid = 1'b1;
    data_in  = VA;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_idle", idle, 1);
      chk("rst_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1 chk("rel_in_ready", in_ready, 0);

    // back-to-back fwd/inv stream; PIPE=2 latency on main, PIPE=3 on twin
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      if (cyc < 6) begin
        in_valid = 1'b1; in_inv = s_inv[cyc]; in_bypass = 1'b0;
        in_tag = s_tag[cyc]; data_in = s_in[cyc];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc < 6) chk("strm_in_ready", in_ready, 1);
      if (cyc >= 2 && cyc < 8) begin
        chk("strm_out_valid", out_valid, 1);
        chk("strm_data", data_out, s_exp[cyc-2]);
        chk("strm_tag", out_tag, s_tag[cyc-2]);
      end else begin
        chk("strm_no_valid", out_valid, 0);
      end
      if (cyc >= 3) begin
        chk("p3_out_valid", v3_out, 1);
        chk("p3_data", data3_out, s_exp[cyc-3]);
        chk("p3_tag", tag3_out, s_tag[cyc-3]);
      end else begin
        chk("p3_no_valid", v3_out, 0);
      end
    end
    @(negedge clk); #1;
    chk("strm_idle", idle, 1);

    // backpressure: out_ready low for 6 cycles
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      if (sent < 4) begin
        in_valid = 1'b1; in_inv = p_inv[sent]; in_bypass = p_byp[sent];
        in_tag = 4'(sent); data_in = p_in[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc < 6) chk("bp_full_ready", in_ready, 0);
      if (cyc == 6) chk("bp_simul_ready", in_ready, 1);
      if (out_valid) begin
        chk("bp_data", data_out, p_exp[got]);
        chk("bp_tag", out_tag, got);
        if (out_ready) got++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk("bp_delivered", got, 4);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_drained_valid", out_valid, 0);
    chk("bp_drained_idle", idle, 1);

    // NCOL=1 columns
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      if (cyc < 5) begin
        v1_in = 1'b1; inv1_in = n_inv[cyc]; byp1_in = n_byp[cyc];
        tag1_in = 4'(cyc); data1_in = n_in[cyc];
      end else begin
        v1_in = 1'b0;
      end
      #1;
      if (cyc < 5) chk("n1_in_ready", r1_ready, 1);
      if (cyc >= 2) begin
        chk("n1_out_valid", v1_out, 1);
        chk("n1_data", data1_out, n_exp[cyc-2]);
        chk("n1_tag", tag1_out, cyc - 2);
      end
    end

    // reset with both stages full and stalled
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_inv = 1'b1; in_bypass = 1'b0; in_tag = 4'd7; data_in = VX2;
    #1 chk("mr_ready0", in_ready, 1);
    @(negedge clk);
    in_inv = 1'b0; in_tag = 4'd8; data_in = VB;
    #1 chk("mr_ready1", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mr_held_valid", out_valid, 1);
    chk("mr_held_data", data_out, IX2);
    rst = 1'b0;
    #1;
    chk("mr_rst_valid", out_valid, 0);
    chk("mr_rst_idle", idle, 1);
    chk("mr_rst_data", data_out, 0);
    @(negedge clk);
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("mr_after_valid", out_valid, 0);
      chk("mr_after_idle", idle, 1);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        in_valid = 1'b1; in_inv = 1'b0; in_bypass = 1'b0; in_tag = 4'd5; data_in = VB;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 0) chk("mr_new_ready", in_ready, 1);
      if (cyc < 2) begin
        chk("mr_new_early", out_valid, 0);
      end else begin
        chk("mr_new_valid", out_valid, 1);
        chk("mr_new_data", data_out, FB);
        chk("mr_new_tag", out_tag, 5);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
